// File: rtl/disp_pkg.sv
// rtl/disp_pkg.sv - shared constants and update record for the display scan path
package disp_pkg;

  localparam int DIGITS    = 4;
  localparam int SUB_TICKS = 16;

  localparam logic [1:0] SEL_D0 = 2'b00;
  localparam logic [1:0] SEL_D1 = 2'b01;
  localparam logic [1:0] SEL_D2 = 2'b11;
  localparam logic [1:0] SEL_D3 = 2'b10;

  typedef struct packed {
    logic [15:0] data;
    logic [3:0]  dp;
    logic        lz;
  } disp_upd_t;

  function automatic logic [1:0] sel_of(input logic [1:0] idx);
    case (idx)
      2'd0:    sel_of = SEL_D0;
      2'd1:    sel_of = SEL_D1;
      2'd2:    sel_of = SEL_D2;
      default: sel_of = SEL_D3;
    endcase
  endfunction

endpackage

// File: rtl/tick_gen.sv
// rtl/tick_gen.sv - free-running prescaler producing a one-cycle tick every TICK_DIV clocks
module tick_gen #(
  parameter int unsigned TICK_DIV = 50000
) (
  input  logic clk,
  input  logic rst_i,
  output logic tick_o
);

  localparam logic [15:0] LAST = 16'(TICK_DIV - 1);

  logic [15:0] cnt_q;

  assign tick_o = (cnt_q == LAST);

  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i)       cnt_q <= '0;
    else if (tick_o) cnt_q <= '0;
    else             cnt_q <= cnt_q + 16'd1;
  end

endmodule

// File: rtl/disp_scan_ctrl.sv
// rtl/disp_scan_ctrl.sv - 4-digit 7-segment scan scheduler with PWM, blanking and
// frame-synchronous double-buffered updates
import disp_pkg::*;

module disp_scan_ctrl #(
  parameter int unsigned TICK_DIV = 50000
) (
  input  logic        clk,
  input  logic        rst_i,
  input  logic        upd_valid_i,
  output logic        upd_ready_o,
  input  logic [15:0] upd_data_i,
  input  logic [3:0]  upd_dp_i,
  input  logic        upd_lz_i,
  input  logic [3:0]  bright_i,
  output logic [4:1]  digi_o,
  output logic [1:0]  sel_o,
  output logic [3:0]  nibble_o,
  output logic        dp_o,
  output logic        frame_o
);

  logic tick;

  tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk    (clk),
    .rst_i  (rst_i),
    .tick_o (tick)
  );

  logic [1:0] dig_q, dig_d;
  logic [3:0] k_q, k_d;
  logic [3:0] bright_q, bright_d;
  disp_upd_t  act_q, act_d, pend_q, pend_d;
  logic       pend_vld_q, pend_vld_d;

  logic [3:0]  digi_d, nibble_d;
  logic [1:0]  sel_d;
  logic        dp_d, frame_d;
  logic        wrap, xfer, sup, en;
  logic [15:0] data;

  assign upd_ready_o = ~pend_vld_q;
  assign xfer        = upd_valid_i & ~pend_vld_q;
  assign wrap        = tick & (k_q == 4'(SUB_TICKS - 1)) & (dig_q == 2'(DIGITS - 1));

  always_comb begin
    k_d        = k_q;
    dig_d      = dig_q;
    act_d      = act_q;
    pend_d     = pend_q;
    pend_vld_d = pend_vld_q;
    if (tick) begin
      k_d = k_q + 4'd1;
      if (k_q == 4'(SUB_TICKS - 1)) dig_d = dig_q + 2'd1;
    end
    // Brightness follows the input through the blank sub-tick and freezes once the slot lights.
    bright_d = (k_q == 4'd0) ? bright_i : bright_q;

    if (wrap && pend_vld_q) begin
      act_d      = pend_q;
      pend_vld_d = 1'b0;
    end
    if (xfer) begin
      pend_d     = '{data: upd_data_i, dp: upd_dp_i, lz: upd_lz_i};
      pend_vld_d = 1'b1;
    end

    // Outputs are computed from next state so the registered values track the state registers.
    data = act_d.data;
    sup  = 1'b0;
    case (dig_d)
      2'd3:    sup = (data[15:12] == 4'd0);
      2'd2:    sup = (data[15:8]  == 8'd0);
      2'd1:    sup = (data[15:4]  == 12'd0);
      default: sup = 1'b0;
    endcase
    sup      = sup & act_d.lz;
    en       = ~sup && (k_d != 4'd0) && (k_d <= bright_d);
    sel_d    = sel_of(dig_d);
    digi_d   = en ? (4'b0001 << dig_d) : 4'b0000;
    nibble_d = data[{dig_d, 2'b00} +: 4];
    dp_d     = en & act_d.dp[dig_d];
    frame_d  = wrap;
  end

  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      dig_q      <= '0;
      k_q        <= '0;
      bright_q   <= '0;
      act_q      <= '0;
      pend_q     <= '0;
      pend_vld_q <= 1'b0;
      digi_o     <= '0;
      sel_o      <= SEL_D0;
      nibble_o   <= '0;
      dp_o       <= 1'b0;
      frame_o    <= 1'b0;
    end else begin
      dig_q      <= dig_d;
      k_q        <= k_d;
      bright_q   <= bright_d;
      act_q      <= act_d;
      pend_q     <= pend_d;
      pend_vld_q <= pend_vld_d;
      digi_o     <= digi_d;
      sel_o      <= sel_d;
      nibble_o   <= nibble_d;
      dp_o       <= dp_d;
      frame_o    <= frame_d;
    end
  end

endmodule
